bist_controller: RTL
====================

Name: bist_controller

Overview:
- Responder side of the bist_start / bist_end / pass_fail handshake that the top-level circular BIST bench drives.
- On a start request it seeds an LFSR pattern generator and switches the CUT (the request arbiter) into test mode.
- It compacts CUT responses into an 8-bit MISR for a fixed number of cycles, then compares the result to a golden signature.
- It reports the signature, pass_fail and bist_end, and holds them until the next run.

Parameters:
- NCYCLES, 32, number of RUN cycles (patterns applied); legal range 2..65535.
- LFSR_W, 4, pattern generator width; width of lfsr_seed and pattern_out.
- SIG_W, 8, MISR / signature width.
- GOLDEN_SIG, 8'h00, expected fault-free signature.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clock rising edge.
- bist_start  in  1  start request; a run is triggered on its rising edge (level 1 sampled while previous sample was 0).
- lfsr_seed  in  LFSR_W  seed, sampled in the START state.
- cut_response  in  SIG_W  CUT outputs to be compacted.
- test_mode  out  1  high while the CUT inputs come from pattern_out.
- pattern_out  out  LFSR_W  current LFSR state, driven to the CUT inputs.
- signature_out  out  SIG_W  final MISR value, valid when bist_end=1.
- bist_end  out  1  run complete; held high in DONE.
- pass_fail  out  1  1 = signature_out equals GOLDEN_SIG; valid when bist_end=1.
- busy  out  1  high in START, RUN and COMPARE.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, lfsr=0, misr=0, cnt=0, start_d=0.
  - All outputs 0.
  - Reset takes priority over everything, including mid-run: the run is abandoned and bist_end is never asserted.
- Start edge: start_d registers bist_start every cycle. start_evt = bist_start & ~start_d.
- FSM states: IDLE, START, RUN, COMPARE, DONE.
- IDLE: on start_evt go to START.
- START (1 cycle):
  - lfsr <= lfsr_seed, or 1 if lfsr_seed==0 (lock-up avoidance).
  - misr <= 0, cnt <= 0, test_mode <= 1, bist_end <= 0, pass_fail <= 0.
  - Go to RUN.
- RUN, every edge:
  - lfsr <= {lfsr[LFSR_W-2:0], lfsr[3]^lfsr[2]} (polynomial x^4+x^3+1).
  - misr <= {misr[6:0],1'b0} ^ (misr[7] ? 8'h1D : 8'h00) ^ cut_response.
  - cnt <= cnt+1.
  - When cnt==NCYCLES-1, go to COMPARE. This gives exactly NCYCLES compaction edges.
- COMPARE (1 cycle):
  - signature_out <= misr, pass_fail <= (misr==GOLDEN_SIG), bist_end <= 1, test_mode <= 0.
  - Go to DONE.
- DONE:
  - Outputs hold.
  - start_evt goes to START, which clears bist_end and pass_fail at that edge.
- start_evt in START, RUN or COMPARE is ignored; there is no restart mid-run.
- pattern_out = lfsr (registered, no combinational path from inputs).
- Latency: if start_evt is sampled at edge k, bist_end rises after edge k+NCYCLES+2.
- cnt width: clog2(NCYCLES)+1; no wrap within a run.

Decomposition:
- Shared package bist_pkg:
  - FSM state typedef.
  - LFSR tap constant (x^4+x^3+1).
  - MISR polynomial constant 8'h1D.
  - Lock-up seed constant 1.
- One sub-module: bist_misr (SIG_W-wide MISR with clear and enable).
- The LFSR and FSM stay inline.

Test Plan:
- Seed 4'hF, NCYCLES=6, pulse start -> pattern_out sequence over RUN: F,E,C,8,1,2; test_mode=1 during RUN only.
- cut_response=8'h00, GOLDEN_SIG=8'h00 -> signature_out=8'h00, pass_fail=1, bist_end rises exactly NCYCLES+2 edges after the start edge.
- NCYCLES=2, cut_response=8'h01 constant -> signature_out=8'h03; with GOLDEN_SIG=8'h00, pass_fail=0.
- Seed 4'h0 -> first pattern_out=4'h1; run completes normally.
- Second start pulse mid-RUN is ignored; reset=0 for one cycle mid-RUN -> all outputs 0 next edge, no bist_end; new start then runs cleanly.
- Two back-to-back runs with identical seed and stimulus from DONE -> identical signature_out; bist_end drops at the START edge of the second run.

Source files
------------

// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bist_pkg
// Description : Shared definitions for the BIST responder. It holds the FSM
//               state type, the pattern-generator feedback taps
//               (x^4+x^3+1), the MISR feedback polynomial and the seed that
//               replaces an all-zero (lock-up) LFSR seed.
// Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

  // Feedback taps for x^4+x^3+1. The new LSB is the XOR of bits 3 and 2.
  localparam logic [3:0] LFSR_TAPS        = 4'b1100;
  // MISR feedback polynomial. It is folded in whenever the MSB shifts out.
  localparam logic [7:0] MISR_POLY        = 8'h1D;
  // An all-zero LFSR never leaves zero, so a zero seed is replaced by this.
  localparam logic [3:0] LFSR_LOCKUP_SEED = 4'h1;

endpackage
`default_nettype wire

// File: rtl/bist_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : bist_controller_if
// Description : Handshake/data bundle between the BIST bench (master) and
//               the BIST controller (slave).
//   master -> slave : bist_start, lfsr_seed[LFSR_W], cut_response[SIG_W]
//   slave -> master : test_mode, pattern_out[LFSR_W], signature_out[SIG_W],
//                     bist_end, pass_fail, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface bist_controller_if #(
  parameter int LFSR_W = 4,
  parameter int SIG_W  = 8
);

  logic              bist_start;
  logic [LFSR_W-1:0] lfsr_seed;
  logic [SIG_W-1:0]  cut_response;
  logic              test_mode;
  logic [LFSR_W-1:0] pattern_out;
  logic [SIG_W-1:0]  signature_out;
  logic              bist_end;
  logic              pass_fail;
  logic              busy;

  modport master (
    output bist_start, lfsr_seed, cut_response,
    input  test_mode, pattern_out, signature_out, bist_end, pass_fail, busy
  );

  modport slave (
    input  bist_start, lfsr_seed, cut_response,
    output test_mode, pattern_out, signature_out, bist_end, pass_fail, busy
  );

endinterface
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ============================================================================
// Module      : bist_misr
// Description : SIG_W-wide multiple-input signature register. Each enabled
//               edge shifts the register left, folds in the polynomial when
//               the MSB leaves, and XORs in the data word. Clear has
//               priority over enable.
//   clock, reset (sync, active-low), clear, enable, data_in[SIG_W],
//   sig_out[SIG_W] (current register contents)
// Revision    : 1.0 - initial release
// ============================================================================
module bist_misr
  import bist_pkg::*;
#(
  parameter int SIG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [SIG_W-1:0] data_in,
  output logic [SIG_W-1:0] sig_out
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

  logic [SIG_W-1:0] misr_q;
  logic [SIG_W-1:0] misr_d;

  always_comb begin
    misr_d = misr_q;
    if (clear) begin
      misr_d = '0;
    end else if (enable) begin
      misr_d = {misr_q[SIG_W-2:0], 1'b0}
             ^ (misr_q[SIG_W-1] ? POLY : '0)
             ^ data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign sig_out = misr_q;

endmodule
`default_nettype wire

// File: rtl/bist_controller.sv
`default_nettype none
// ============================================================================
// Module      : bist_controller
// Description : Responder side of the bist_start / bist_end / pass_fail
//               handshake. A rising edge on bist_start seeds the LFSR pattern
//               generator and puts the CUT into test mode. CUT responses are
//               then compacted for NCYCLES edges and the signature is
//               compared against GOLDEN_SIG. The results are held until the
//               next run starts.
//   clock          : system clock, rising edge
//   reset          : synchronous, active-low
//   bus (slave)    : bist_start, lfsr_seed, cut_response in;
//                    test_mode, pattern_out, signature_out, bist_end,
//                    pass_fail, busy out
// Revision    : 1.0 - initial release
// ============================================================================
module bist_controller
  import bist_pkg::*;
#(
  parameter int               NCYCLES    = 32,
  parameter int               LFSR_W     = 4,
  parameter int               SIG_W      = 8,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic              clock,
  input  logic              reset,
  bist_controller_if.slave  bus
);

  // One spare bit so the counter never wraps within a run.
  localparam int                  CNT_W       = $clog2(NCYCLES) + 1;
  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(NCYCLES - 1);
  localparam logic [LFSR_W-1:0]   TAPS        = LFSR_W'(LFSR_TAPS);
  localparam logic [LFSR_W-1:0]   SEED_LOCKUP = LFSR_W'(LFSR_LOCKUP_SEED);

  bist_state_e       state_q,     state_d;
  logic [LFSR_W-1:0] lfsr_q,      lfsr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              start_dly_q;
  logic              test_mode_q, test_mode_d;
  logic [SIG_W-1:0]  signature_q, signature_d;
  logic              bist_end_q,  bist_end_d;
  logic              pass_fail_q, pass_fail_d;

  logic              start_evt;
  logic              misr_clear;
  logic              misr_enable;
  logic [SIG_W-1:0]  misr_value;

  // A level that is held high starts only one run.
  assign start_evt   = bus.bist_start & ~start_dly_q;
  assign misr_clear  = (state_q == ST_START);
  assign misr_enable = (state_q == ST_RUN);

  bist_misr #(
    .SIG_W   (SIG_W)
  ) u_misr (
    .clock   (clock),
    .reset   (reset),
    .clear   (misr_clear),
    .enable  (misr_enable),
    .data_in (bus.cut_response),
    .sig_out (misr_value)
  );

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    test_mode_d = test_mode_q;
    signature_d = signature_q;
    bist_end_d  = bist_end_q;
    pass_fail_d = pass_fail_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        lfsr_d      = (bus.lfsr_seed == '0) ? SEED_LOCKUP : bus.lfsr_seed;
        cnt_d       = '0;
        test_mode_d = 1'b1;
        bist_end_d  = 1'b0;
        pass_fail_d = 1'b0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        cnt_d  = cnt_q + 1'b1;
        // cnt starts at 0, so leaving on NCYCLES-1 gives NCYCLES
        // compaction edges.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        signature_d = misr_value;
        pass_fail_d = (misr_value == GOLDEN_SIG);
        bist_end_d  = 1'b1;
        test_mode_d = 1'b0;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (start_evt) begin
          state_d = ST_START;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= '0;
      cnt_q       <= '0;
      start_dly_q <= 1'b0;
      test_mode_q <= 1'b0;
      signature_q <= '0;
      bist_end_q  <= 1'b0;
      pass_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      start_dly_q <= bus.bist_start;
      test_mode_q <= test_mode_d;
      signature_q <= signature_d;
      bist_end_q  <= bist_end_d;
      pass_fail_q <= pass_fail_d;
    end
  end

  assign bus.test_mode     = test_mode_q;
  assign bus.pattern_out   = lfsr_q;
  assign bus.signature_out = signature_q;
  assign bus.bist_end      = bist_end_q;
  assign bus.pass_fail     = pass_fail_q;
  assign bus.busy          = (state_q == ST_START) || (state_q == ST_RUN) ||
                             (state_q == ST_COMPARE);

endmodule
`default_nettype wire
